// File: rtl/ppi_psg_sequencer_pkg.sv
// Shared types and constants for the PPI/PSG command sequencer.
//   op_e       : high-level command opcodes
//   BC_*       : BDIR/BC1 codes placed in port C bits [7:6]
//   step_e     : individual PPI register cycles a command is built from
//   step_of()  : maps (opcode, step index) to the step to perform
//   step_count(): number of steps an opcode runs
package ppi_seq_pkg;

    typedef enum logic [1:0] {
        OP_PSG_WR = 2'b00,
        OP_PSG_RD = 2'b01,
        OP_KBD_RD = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    // {BDIR, BC1}
    localparam logic [1:0] BC_LATCH = 2'b11;
    localparam logic [1:0] BC_WRITE = 2'b10;
    localparam logic [1:0] BC_READ  = 2'b01;
    localparam logic [1:0] BC_INACT = 2'b00;

    typedef enum logic [3:0] {
        SET_MODE_OUT,
        WR_A_REG,
        C_LATCH,
        C_INACT,
        WR_A_DATA,
        C_WRITE,
        SET_MODE_IN,
        C_READ,
        RD_A,
        RESTORE_MODE,
        RESTORE_C
    } step_e;

    localparam logic [7:0] RESET_MODE  = 8'h9B;
    localparam logic [3:0] KBD_PSG_REG = 4'd14;

    function automatic step_e step_of(op_e op, logic [3:0] idx);
        step_e s;
        s = RESTORE_C;
        if (op == OP_PSG_WR) begin
            case (idx)
                4'd0:    s = SET_MODE_OUT;
                4'd1:    s = WR_A_REG;
                4'd2:    s = C_LATCH;
                4'd3:    s = C_INACT;
                4'd4:    s = WR_A_DATA;
                4'd5:    s = C_WRITE;
                4'd6:    s = C_INACT;
                4'd7:    s = RESTORE_MODE;
                default: s = RESTORE_C;
            endcase
        end else begin
            // PSG read and keyboard row read share one list
            case (idx)
                4'd0:    s = SET_MODE_OUT;
                4'd1:    s = WR_A_REG;
                4'd2:    s = C_LATCH;
                4'd3:    s = C_INACT;
                4'd4:    s = SET_MODE_IN;
                4'd5:    s = C_READ;
                4'd6:    s = RD_A;
                4'd7:    s = C_INACT;
                4'd8:    s = RESTORE_MODE;
                default: s = RESTORE_C;
            endcase
        end
        return s;
    endfunction

    function automatic logic [3:0] step_count(op_e op);
        logic [3:0] n;
        case (op)
            OP_PSG_WR: n = 4'd9;
            OP_PSG_RD: n = 4'd10;
            OP_KBD_RD: n = 4'd10;
            default:   n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ppi_psg_sequencer_shadow.sv
// ppi_shadow: snoops CPU writes accepted by the i8255 and keeps a copy of the
// mode word and the port C latch so a sequence can put them back afterwards.
//   clk_sys, reset      : clock, synchronous active-high reset
//   wr_en               : a CPU write reaches the PPI this cycle
//   addr, data          : that write's register address and data
//   shadow_mode/shadow_c: tracked control word / port C value
module ppi_shadow
    import ppi_seq_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] addr,
    input  logic [7:0] data,
    output logic [7:0] shadow_mode,
    output logic [7:0] shadow_c
);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shadow_mode <= RESET_MODE;
            shadow_c    <= '0;
        end else if (wr_en) begin
            case (addr)
                2'd3: begin
                    if (data[7]) begin
                        // a mode set clears all port outputs in the 8255
                        shadow_mode <= data;
                        shadow_c    <= '0;
                    end else begin
                        // port C bit set/reset
                        shadow_c[data[3:1]] <= data[0];
                    end
                end
                2'd2:    shadow_c <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ppi_psg_sequencer.sv
// ppi_psg_sequencer: arbitrates the i8255 register bus between the Z80 and a
// command port, expanding PSG write / PSG read / keyboard row read commands
// into atomic series of PPI register cycles.
//   clk_sys, reset                 : clock, synchronous active-high reset
//   cpu_addr/idata/cs/we/oe, wait  : CPU side of the PPI bus, stall output
//   cmd_valid/ready/op/reg/data    : command handshake
//   rsp_valid, rsp_data            : completion pulse and read result
//   ppi_addr/idata/cs/we/oe, odata : i8255 register bus
module ppi_psg_sequencer
    import ppi_seq_pkg::*;
#(
    parameter int         GAP      = 1,
    parameter logic [7:0] MODE_OUT = 8'h82,
    parameter logic [7:0] MODE_IN  = 8'h92
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_idata,
    input  logic       cpu_cs,
    input  logic       cpu_we,
    input  logic       cpu_oe,
    output logic       cpu_wait,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] ppi_addr,
    output logic [7:0] ppi_idata,
    output logic       ppi_cs,
    output logic       ppi_we,
    output logic       ppi_oe,
    input  logic [7:0] ppi_odata
);

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP_WAIT, RESP} state_e;

    state_e     state, state_nxt;
    op_e        op_q;
    logic [3:0] reg_q;
    logic [7:0] data_q;
    logic [3:0] step_idx;
    logic [GW-1:0] gap_cnt;

    logic [7:0] shadow_mode, shadow_c;
    step_e      cur_step;
    logic       accept, gap_last, last_step;
    logic [3:0] c_low;
    logic [5:0] c_base;

    assign cur_step  = step_of(op_q, step_idx);
    assign gap_last  = (gap_cnt == GW'(GAP - 1));
    assign last_step = (step_idx == step_count(op_q) - 4'd1);
    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;

    // keyboard reads put the row on the decoder lines; otherwise keep the CPU's
    assign c_low  = (op_q == OP_KBD_RD) ? reg_q : shadow_c[3:0];
    assign c_base = {shadow_c[5:4], c_low};

    ppi_shadow u_shadow (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .wr_en       ((state == IDLE) && cpu_cs && cpu_we),
        .addr        (cpu_addr),
        .data        (cpu_idata),
        .shadow_mode (shadow_mode),
        .shadow_c    (shadow_c)
    );

    // state register
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = (op_e'(cmd_op) == OP_RSVD) ? RESP : ACCESS;
            ACCESS:   state_nxt = GAP_WAIT;
            GAP_WAIT: if (gap_last) state_nxt = last_step ? RESP : ACCESS;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // command latch, step/gap counters, read capture
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            op_q     <= OP_PSG_WR;
            reg_q    <= '0;
            data_q   <= '0;
            step_idx <= '0;
            gap_cnt  <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= op_e'(cmd_op);
                    reg_q    <= cmd_reg;
                    data_q   <= cmd_data;
                    step_idx <= '0;
                    gap_cnt  <= '0;
                    rsp_data <= '0;
                end
                ACCESS: gap_cnt <= '0;
                GAP_WAIT: begin
                    // i8255 registers its read data, so it is valid one cycle after oe
                    if (cur_step == RD_A && gap_cnt == '0) rsp_data <= ppi_odata;
                    if (gap_last) step_idx <= step_idx + 4'd1;
                    else          gap_cnt  <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

    // outputs
    always_comb begin
        ppi_addr  = '0;
        ppi_idata = '0;
        ppi_cs    = 1'b0;
        ppi_we    = 1'b0;
        ppi_oe    = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        cpu_wait  = cpu_cs && (state != IDLE);
        case (state)
            IDLE: begin
                ppi_addr  = cpu_addr;
                ppi_idata = cpu_idata;
                ppi_cs    = cpu_cs;
                ppi_we    = cpu_we;
                ppi_oe    = cpu_oe;
                // CPU has priority on a same-cycle collision
                cmd_ready = !(cpu_cs && cmd_valid);
            end
            ACCESS: begin
                ppi_cs = 1'b1;
                ppi_we = 1'b1;
                case (cur_step)
                    SET_MODE_OUT: begin ppi_addr = 2'd3; ppi_idata = MODE_OUT; end
                    WR_A_REG: begin
                        ppi_addr  = 2'd0;
                        ppi_idata = {4'h0, (op_q == OP_KBD_RD) ? KBD_PSG_REG : reg_q};
                    end
                    C_LATCH:      begin ppi_addr = 2'd2; ppi_idata = {BC_LATCH, c_base}; end
                    C_INACT:      begin ppi_addr = 2'd2; ppi_idata = {BC_INACT, c_base}; end
                    WR_A_DATA:    begin ppi_addr = 2'd0; ppi_idata = data_q; end
                    C_WRITE:      begin ppi_addr = 2'd2; ppi_idata = {BC_WRITE, c_base}; end
                    SET_MODE_IN:  begin ppi_addr = 2'd3; ppi_idata = MODE_IN; end
                    C_READ:       begin ppi_addr = 2'd2; ppi_idata = {BC_READ, c_base}; end
                    RD_A: begin
                        ppi_addr = 2'd0;
                        ppi_we   = 1'b0;
                        ppi_oe   = 1'b1;
                    end
                    RESTORE_MODE: begin ppi_addr = 2'd3; ppi_idata = shadow_mode; end
                    RESTORE_C:    begin ppi_addr = 2'd2; ppi_idata = shadow_c; end
                    default: ;
                endcase
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ppi_psg_sequencer.sv
module tb_ppi_psg_sequencer;

    localparam int GAP = 1;
    localparam logic [7:0] MODE_OUT = 8'h82;
    localparam logic [7:0] MODE_IN  = 8'h92;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cpu_addr = '0;
    logic [7:0] cpu_idata = '0;
    logic       cpu_cs = 1'b0, cpu_we = 1'b0, cpu_oe = 1'b0;
    logic       cpu_wait;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_reg = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] ppi_addr;
    logic [7:0] ppi_idata;
    logic       ppi_cs, ppi_we, ppi_oe;
    logic [7:0] ppi_odata = '0;

    ppi_psg_sequencer #(.GAP(GAP), .MODE_OUT(MODE_OUT), .MODE_IN(MODE_IN)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_idata(cpu_idata), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_oe(cpu_oe), .cpu_wait(cpu_wait),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ppi_addr(ppi_addr), .ppi_idata(ppi_idata), .ppi_cs(ppi_cs), .ppi_we(ppi_we),
        .ppi_oe(ppi_oe), .ppi_odata(ppi_odata)
    );

    always #5 clk_sys = ~clk_sys;

    // i8255 port A read: data registered at the edge ending the oe cycle
    logic [7:0] porta_val = '0;
    logic       oe_seen = 1'b0;
    always @(negedge clk_sys) oe_seen <= ppi_cs && ppi_oe && (ppi_addr == 2'd0);
    always @(posedge clk_sys) if (oe_seen) ppi_odata <= porta_val;

    int total = 0;
    int bad = 0;

    // reference state: what the CPU has programmed into the PPI
    logic [7:0] m_mode = 8'h9B;
    logic [7:0] m_c = 8'h00;

    // access encoding {oe, we, addr, data}; data is 0 for reads
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    int          got_cyc[$];

    typedef struct {
        logic       pre_en;
        logic [1:0] pre_a;
        logic [7:0] pre_d;
        logic [1:0] op;
        logic [3:0] r;
        logic [7:0] d;
        logic [7:0] pa;
        int         exp_cyc;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vt [0:5];
    logic [11:0] lit1 [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic shadow_upd(input logic [1:0] a, input logic [7:0] d);
        if (a == 2'd3) begin
            if (d[7]) begin m_mode = d; m_c = 8'h00; end
            else m_c[d[3:1]] = d[0];
        end else if (a == 2'd2) begin
            m_c = d;
        end
    endtask

    function automatic logic [11:0] wacc(input logic [1:0] a, input logic [7:0] d);
        return {2'b01, a, d};
    endfunction

    function automatic logic [7:0] cval(input logic [1:0] bc, input logic [1:0] op, input logic [3:0] r);
        return {bc, m_c[5:4], (op == 2'd2) ? r : m_c[3:0]};
    endfunction

    function automatic int steps_of(input logic [1:0] op);
        return (op == 2'd0) ? 9 : (op == 2'd3) ? 0 : 10;
    endfunction

    // expected access list from the command description
    task automatic build_expect(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d);
        exp_q.delete();
        if (op == 2'd3) return;
        exp_q.push_back(wacc(2'd3, MODE_OUT));
        exp_q.push_back(wacc(2'd0, (op == 2'd2) ? 8'd14 : {4'h0, r}));
        exp_q.push_back(wacc(2'd2, cval(2'b11, op, r)));
        exp_q.push_back(wacc(2'd2, cval(2'b00, op, r)));
        if (op == 2'd0) begin
            exp_q.push_back(wacc(2'd0, d));
            exp_q.push_back(wacc(2'd2, cval(2'b10, op, r)));
            exp_q.push_back(wacc(2'd2, cval(2'b00, op, r)));
        end else begin
            exp_q.push_back(wacc(2'd3, MODE_IN));
            exp_q.push_back(wacc(2'd2, cval(2'b01, op, r)));
            exp_q.push_back(12'h800);
            exp_q.push_back(wacc(2'd2, cval(2'b00, op, r)));
        end
        exp_q.push_back(wacc(2'd3, m_mode));
        exp_q.push_back(wacc(2'd2, m_c));
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_oe = 1'b0; cpu_addr = a; cpu_idata = d;
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        shadow_upd(a, d);
    endtask

    // issue one command and check the whole sequence; cpu_at / rst_at >= 0
    // inject a CPU read or a reset at that cycle after acceptance
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d,
                           input logic [7:0] pa, input int exp_cyc, input logic [7:0] exp_rsp,
                           input int cpu_at, input int rst_at, input string tag);
        int waitn, cyc_n, rsp_cyc, nrsp, nwait, late;
        logic [7:0] rsp_d;
        logic aborted;
        build_expect(op, r, d);
        porta_val = pa; cmd_op = op; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
        waitn = 0;
        #2;
        while (!cmd_ready && waitn < 50) begin tick(); waitn++; #2; end
        check($sformatf("%s accept_wait", tag), waitn, 0);
        tick();
        cmd_valid = 1'b0;
        cyc_n = 1; nrsp = 0; rsp_cyc = -1; nwait = 0; aborted = 1'b0; rsp_d = '0;
        got_q.delete(); got_cyc.delete();
        while (cyc_n < 60 && nrsp == 0 && !aborted) begin
            if (cyc_n == cpu_at) begin cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd1; end
            if (cyc_n == rst_at) reset = 1'b1;
            #2;
            if (ppi_cs) begin
                got_q.push_back({ppi_oe, ppi_we, ppi_addr, ppi_oe ? 8'h00 : ppi_idata});
                got_cyc.push_back(cyc_n);
            end
            if (rsp_valid) begin nrsp++; rsp_cyc = cyc_n; rsp_d = rsp_data; end
            if (cpu_wait) nwait++;
            tick();
            if (cyc_n == rst_at) begin reset = 1'b0; aborted = 1'b1; end
            cyc_n++;
        end
        if (aborted) begin
            m_mode = 8'h9B; m_c = 8'h00;
            #2;
            check($sformatf("%s rst ppi_cs", tag), ppi_cs, 0);
            check($sformatf("%s rst rsp_valid", tag), rsp_valid, 0);
            check($sformatf("%s rst cmd_ready", tag), cmd_ready, 1);
            late = 0;
            for (int k = 0; k < 25; k++) begin tick(); #2; if (rsp_valid) late++; end
            check($sformatf("%s rst late_rsp", tag), late, 0);
            tick();
            return;
        end
        check($sformatf("%s rsp_cycle", tag), rsp_cyc, exp_cyc);
        check($sformatf("%s rsp_data", tag), rsp_d, exp_rsp);
        check($sformatf("%s n_access", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s acc%0d", tag, i), got_q[i], exp_q[i]);
            check($sformatf("%s acc%0d_cycle", tag, i), got_cyc[i], 1 + i * (1 + GAP));
        end
        #2;
        check($sformatf("%s rsp_pulse_end", tag), rsp_valid, 0);
        if (cpu_at >= 0) begin
            check($sformatf("%s wait_cycles", tag), nwait, rsp_cyc - cpu_at + 1);
            check($sformatf("%s wait_released", tag), cpu_wait, 0);
            check($sformatf("%s cpu_pass", tag), {ppi_cs, ppi_oe, ppi_we, ppi_addr}, 5'b11001);
            tick();
            cpu_cs = 1'b0; cpu_oe = 1'b0;
        end else begin
            check($sformatf("%s ready_after", tag), cmd_ready, 1);
            tick();
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 2'd0, 8'h00, 2'd1, 4'd8, 8'h00, 8'h0A, 21, 8'h0A};
        vt[1] = '{1'b1, 2'd2, 8'h0F, 2'd2, 4'd4, 8'h00, 8'h5A, 21, 8'h5A};
        vt[2] = '{1'b0, 2'd0, 8'h00, 2'd3, 4'd2, 8'h77, 8'hEE, 1,  8'h00};
        vt[3] = '{1'b1, 2'd3, 8'h07, 2'd0, 4'd15, 8'hFF, 8'h12, 19, 8'h00};
        vt[4] = '{1'b1, 2'd3, 8'h9B, 2'd1, 4'd0, 8'h00, 8'hFF, 21, 8'hFF};
        vt[5] = '{1'b1, 2'd2, 8'hF3, 2'd2, 4'd9, 8'h00, 8'h00, 21, 8'h00};
        lit1 = '{12'h782, 12'h407, 12'h6C5, 12'h605, 12'h43F, 12'h685, 12'h605, 12'h782, 12'h605};

        // reset state
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        #2;
        check("reset cmd_ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset cpu_wait", cpu_wait, 0);
        check("reset ppi", {ppi_cs, ppi_we, ppi_oe, ppi_addr, ppi_idata}, 0);
        tick();

        // PSG write after CPU programs mode and port C
        cpu_wr(2'd3, 8'h82);
        cpu_wr(2'd2, 8'h05);
        run_cmd(2'd0, 4'd7, 8'h3F, 8'h00, 19, 8'h00, -1, -1, "psgwr");
        for (int i = 0; i < 9; i++)
            check($sformatf("psgwr literal%0d", i), (i < got_q.size()) ? got_q[i] : 12'hFFF, lit1[i]);

        // table of commands
        for (int i = 0; i < 6; i++) begin
            if (vt[i].pre_en) cpu_wr(vt[i].pre_a, vt[i].pre_d);
            run_cmd(vt[i].op, vt[i].r, vt[i].d, vt[i].pa, vt[i].exp_cyc, vt[i].exp_rsp,
                    -1, -1, $sformatf("vec%0d", i));
            if (i == 0)
                check("vec0 step5_mode_in", (got_q.size() > 4) ? got_q[4] : 12'hFFF, 12'h792);
        end

        // CPU and command collide in the same idle cycle
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_oe = 1'b0; cpu_addr = 2'd2; cpu_idata = 8'h30;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_reg = 4'd3; cmd_data = 8'hA5;
        #2;
        check("collide cmd_ready", cmd_ready, 0);
        check("collide ppi", {ppi_cs, ppi_we, ppi_oe, ppi_addr, ppi_idata}, {3'b110, 2'd2, 8'h30});
        tick();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        shadow_upd(2'd2, 8'h30);
        run_cmd(2'd0, 4'd3, 8'hA5, 8'h00, 19, 8'h00, -1, -1, "collide");

        // CPU access during a write sequence is stalled until IDLE
        run_cmd(2'd0, 4'd1, 8'h44, 8'h00, 19, 8'h00, 5, -1, "cpuwait");

        // reset mid-read, then shadows must be back at their reset values
        run_cmd(2'd1, 4'd8, 8'h00, 8'h0A, 21, 8'h0A, -1, 8, "rstmid");
        run_cmd(2'd0, 4'd1, 8'h11, 8'h00, 19, 8'h00, -1, -1, "postrst");
        check("postrst restore_mode", (got_q.size() == 9) ? got_q[7] : 12'hFFF, 12'h79B);
        check("postrst restore_c", (got_q.size() == 9) ? got_q[8] : 12'hFFF, 12'h600);

        // randomized commands against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [3:0] r;
            logic [7:0] d, pa;
            op = 2'($urandom_range(0, 3));
            r  = 4'($urandom);
            d  = 8'($urandom);
            pa = 8'($urandom);
            if ($urandom_range(0, 1) == 1) cpu_wr(2'($urandom_range(2, 3)), 8'($urandom));
            run_cmd(op, r, d, pa, steps_of(op) * (1 + GAP) + 1,
                    (op == 2'd1 || op == 2'd2) ? pa : 8'h00, -1, -1, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
